router_input_ctrl_sep: RTL and testbench
========================================

Name: router_input_ctrl_sep

Overview:
Per-input-port stage of a ring-network router, placed directly upstream of each output port's arbitration and control logic.
- Buffers incoming packets in a small FIFO, together with each packet's security-domain bit.
- Computes the route for the head packet.
- Drives one-hot request lines, one per output port, with the head packet's domain beside them.
- Dequeues the head packet when the output port it requested grants it.
- Request and grant use separate wires for each output port, so one input block connects to three output arbiters.

Parameters:
P_MSG_NBITS, 44, packet width in bits; the destination field is the top P_DEST_NBITS bits.
P_NUM_ROUTERS, 4, number of routers on the ring; must be at least 2.
P_DEST_NBITS, 2, destination id width; equals clog2(P_NUM_ROUTERS).
P_QUEUE_DEPTH, 2, number of input FIFO entries; must be at least 2.
P_ROUTER_ID, 0, this router's id on the ring.

Ports:
clk  in  1  clock
reset  in  1  reset
in_val  in  1  upstream packet valid
in_rdy  out  1  FIFO can accept a packet
in_msg  in  P_MSG_NBITS  incoming packet
in_domain  in  1  incoming packet domain (0 = non-secure, 1 = secure)
reqs_p0  out  1  head packet requests output port 0 (counter-clockwise neighbour)
reqs_p1  out  1  head packet requests output port 1 (terminal)
reqs_p2  out  1  head packet requests output port 2 (clockwise neighbour)
grants_p0  in  1  output port 0 grants this input
grants_p1  in  1  output port 1 grants this input
grants_p2  in  1  output port 2 grants this input
reqs_domain  out  1  domain of the head packet; 0 when the FIFO is empty
head_msg  out  P_MSG_NBITS  head packet, to the crossbar

Behaviour:
- Reset is synchronous and active-high. While reset is asserted the FIFO pointers and count clear to 0.
- Output values in the first cycle after reset:
  - in_rdy = 1.
  - reqs_p0, reqs_p1, reqs_p2 = 0.
  - reqs_domain = 0.
  - head_msg = 0. Storage is cleared to 0, or head_msg is masked to 0 when empty.
- Reset in the middle of operation discards all buffered packets. Grants that arrive in the reset cycle are ignored.
- Enqueue fires when in_val && in_rdy; msg and domain are written at the tail.
- in_rdy = !full. It depends only on FIFO state, never on the grants, so there is no combinational path from grants to in_rdy. A full FIFO with a grant in the same cycle still shows in_rdy = 0.
- The FIFO has no bypass. A packet enqueued in cycle t can raise a request no earlier than cycle t+1, so input-to-request latency is 1 cycle.
- Route computation is combinational from head_msg's destination field:
  - fwd = (dest - P_ROUTER_ID) mod P_NUM_ROUTERS, computed at P_DEST_NBITS+1 bits and then wrapped.
  - If fwd == 0, route to p1.
  - Else if fwd <= P_NUM_ROUTERS/2, route to p2. A tie at N/2 goes clockwise to p2.
  - Otherwise route to p0.
- A request is asserted only when !empty, and exactly one of reqs_p0, reqs_p1, reqs_p2 is high.
- Requests are held stable until granted. The head packet, its route and reqs_domain do not change while the head is waiting.
- Dequeue fires when the requested port's grant is high in the same cycle, i.e. (reqs_pX && grants_pX) for the routed port X. The read pointer advances at the clock edge.
- A grant on a port that was not requested, or any grant while empty, is ignored and causes no dequeue. The bench flags it as a protocol error.
- More than one grant in a cycle: only the grant on the requested port counts.
- An enqueue and a dequeue in the same cycle leave the count unchanged, and both pointers advance.
- Pointers wrap modulo P_QUEUE_DEPTH.
- The count ranges from 0 to P_QUEUE_DEPTH. full = (count == P_QUEUE_DEPTH); empty = (count == 0).
- Back-to-back throughput is one packet per cycle when grants are held high.
- reqs_domain is a per-entry stored bit and is never recomputed from the message. The output control uses it to steer its output domain, so it must be valid in the same cycle as the request.

Decomposition:
- A shared net package holds:
  - the port index constants (PORT_CCW = 0, PORT_TERM = 1, PORT_CW = 2);
  - the domain constants (DOM_NS = 0, DOM_S = 1);
  - the destination-field slice macros for the message format.
- One natural sub-module: vc_queue_domain, a normal-mode FIFO storing {domain, msg} with enq/deq val/rdy, count, full and empty.
- Route computation and grant decode stay inline in router_input_ctrl_sep.

Test Plan:
All scenarios use P_ROUTER_ID = 1 and P_NUM_ROUTERS = 4.
1. Reset: hold reset for 2 cycles with in_val = 1 → in_rdy = 1, all reqs = 0, reqs_domain = 0, and nothing is enqueued.
2. Routing: enqueue dest = 1, then 2, then 3, then 0, granting each head → the requests in order are reqs_p1, reqs_p2, reqs_p2 (tie fwd = 2 goes clockwise), reqs_p0. Each request appears 1 cycle after its enqueue.
3. Fill and hold: enqueue 2 packets with domains 1 then 0 and give no grants → in_rdy = 0 after the second enqueue. reqs_domain = 1 and the request is held stable for 10 cycles. A third in_val is not accepted.
4. Wrong grant: head routed to p2, pulse grants_p0 and grants_p1 → no dequeue, count is unchanged, head_msg is unchanged.
5. Streaming: in_val = 1 every cycle with dest = 2 and grants_p2 = 1 every cycle → one packet per cycle in order, count stays at 1, and in_rdy stays 1.
6. Reset mid-operation: with the FIFO full, assert reset for 1 cycle → the next cycle shows empty, in_rdy = 1, all reqs = 0, and old packets never reappear.

Source files
------------

// File: rtl/router_input_ctrl_sep_pkg.sv
// Shared ring-network definitions: output port indices, security domains, message field slices.
// Pure declarations; no logic, no latency, no flow control.
`ifndef ROUTER_INPUT_CTRL_SEP_PKG_SV
`define ROUTER_INPUT_CTRL_SEP_PKG_SV

// Destination id occupies the most-significant bits of every message.
`define RIC_DEST_HI(MSG_NBITS) ((MSG_NBITS) - 1)
`define RIC_DEST_LO(MSG_NBITS, DEST_NBITS) ((MSG_NBITS) - (DEST_NBITS))

package router_input_ctrl_sep_pkg;

    localparam int NUM_PORTS = 3;
    localparam int PORT_CCW  = 0;
    localparam int PORT_TERM = 1;
    localparam int PORT_CW   = 2;

    localparam logic DOM_NS = 1'b0;
    localparam logic DOM_S  = 1'b1;

endpackage

`endif

// File: rtl/router_input_ctrl_sep_if.sv
// Bundle between one router input port, its upstream link and the three output arbiters.
// slave = the input control block; master = upstream sender plus the arbiters' grant side.
interface router_input_ctrl_sep_if #(
    parameter int P_MSG_NBITS = 44
);
    logic                   in_val;
    logic                   in_rdy;
    logic [P_MSG_NBITS-1:0] in_msg;
    logic                   in_domain;
    logic                   reqs_p0;
    logic                   reqs_p1;
    logic                   reqs_p2;
    logic                   grants_p0;
    logic                   grants_p1;
    logic                   grants_p2;
    logic                   reqs_domain;
    logic [P_MSG_NBITS-1:0] head_msg;

    modport master (
        output in_val, in_msg, in_domain, grants_p0, grants_p1, grants_p2,
        input  in_rdy, reqs_p0, reqs_p1, reqs_p2, reqs_domain, head_msg
    );

    modport slave (
        input  in_val, in_msg, in_domain, grants_p0, grants_p1, grants_p2,
        output in_rdy, reqs_p0, reqs_p1, reqs_p2, reqs_domain, head_msg
    );
endinterface

// File: rtl/router_input_ctrl_sep_vc_queue_domain.sv
// Normal-mode FIFO of {domain, msg} entries; enqueue-to-visible latency 1 cycle, no bypass.
// enq_rdy = !full, independent of deq_rdy; dequeue only when deq_val && deq_rdy.
module vc_queue_domain #(
    parameter int P_DATA_NBITS = 45,
    parameter int P_DEPTH      = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enq_val,
    output logic                           enq_rdy,
    input  logic [P_DATA_NBITS-1:0]        enq_data,
    output logic                           deq_val,
    input  logic                           deq_rdy,
    output logic [P_DATA_NBITS-1:0]        deq_data,
    output logic [$clog2(P_DEPTH+1)-1:0]   count,
    output logic                           full,
    output logic                           empty
);
    localparam int PTR_W = $clog2(P_DEPTH);
    localparam int CNT_W = $clog2(P_DEPTH + 1);

    logic [P_DATA_NBITS-1:0] mem [P_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    enq_fire;
    logic                    deq_fire;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(P_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(P_DEPTH));
    assign empty    = (count == '0);
    assign enq_rdy  = !full;
    assign deq_val  = !empty;
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;
    assign deq_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (deq_fire) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (enq_fire && !deq_fire) begin
                count <= count + CNT_W'(1);
            end else if (deq_fire && !enq_fire) begin
                count <= count - CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/router_input_ctrl_sep.sv
// Router input port: buffer packets, route the head, request one output port; request 1 cycle after enqueue.
// in_rdy = !full only (no grant path); head leaves when its requested port grants it.
module router_input_ctrl_sep
    import router_input_ctrl_sep_pkg::*;
#(
    parameter int P_MSG_NBITS   = 44,
    parameter int P_NUM_ROUTERS = 4,
    parameter int P_DEST_NBITS  = 2,
    parameter int P_QUEUE_DEPTH = 2,
    parameter int P_ROUTER_ID   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    router_input_ctrl_sep_if.slave ifc
);
    localparam int DATA_NBITS = P_MSG_NBITS + 1;
    localparam int CNT_W      = $clog2(P_QUEUE_DEPTH + 1);
    localparam int FWD_W      = P_DEST_NBITS + 1;
    localparam logic [FWD_W-1:0] ID_W   = FWD_W'(P_ROUTER_ID);
    localparam logic [FWD_W-1:0] NUM_W  = FWD_W'(P_NUM_ROUTERS);
    localparam logic [FWD_W-1:0] HALF_W = FWD_W'(P_NUM_ROUTERS / 2);

    logic [DATA_NBITS-1:0]   head_data;
    logic [P_MSG_NBITS-1:0]  head_raw;
    logic                    head_dom;
    logic                    head_vld;
    logic                    deq_rdy;
    logic [CNT_W-1:0]        count;
    logic                    full;
    logic                    empty;
    logic [P_DEST_NBITS-1:0] dest;
    logic [FWD_W-1:0]        dest_w;
    logic [FWD_W-1:0]        fwd;
    logic [NUM_PORTS-1:0]    reqs;
    logic [NUM_PORTS-1:0]    grants;

    vc_queue_domain #(
        .P_DATA_NBITS (DATA_NBITS),
        .P_DEPTH      (P_QUEUE_DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (ifc.in_val),
        .enq_rdy  (ifc.in_rdy),
        .enq_data ({ifc.in_domain, ifc.in_msg}),
        .deq_val  (head_vld),
        .deq_rdy  (deq_rdy),
        .deq_data (head_data),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign {head_dom, head_raw} = head_data;
    assign dest   = head_raw[`RIC_DEST_HI(P_MSG_NBITS):`RIC_DEST_LO(P_MSG_NBITS, P_DEST_NBITS)];
    assign dest_w = {1'b0, dest};

    // Hop distance going clockwise; one extra bit keeps dest + N - id from overflowing.
    always_comb begin
        if (dest_w >= ID_W) begin
            fwd = dest_w - ID_W;
        end else begin
            fwd = dest_w + NUM_W - ID_W;
        end
    end

    // Half-way ties go clockwise.
    always_comb begin
        reqs = '0;
        if (head_vld) begin
            if (fwd == '0) begin
                reqs[PORT_TERM] = 1'b1;
            end else if (fwd <= HALF_W) begin
                reqs[PORT_CW] = 1'b1;
            end else begin
                reqs[PORT_CCW] = 1'b1;
            end
        end
    end

    assign grants[PORT_CCW]  = ifc.grants_p0;
    assign grants[PORT_TERM] = ifc.grants_p1;
    assign grants[PORT_CW]   = ifc.grants_p2;

    // Grants on unrequested ports fall out of the AND and never dequeue.
    assign deq_rdy = |(reqs & grants);

    assign ifc.reqs_p0     = reqs[PORT_CCW];
    assign ifc.reqs_p1     = reqs[PORT_TERM];
    assign ifc.reqs_p2     = reqs[PORT_CW];
    assign ifc.reqs_domain = empty ? DOM_NS : head_dom;
    assign ifc.head_msg    = empty ? '0 : head_raw;

    a_count_range : assert property (@(posedge clk) disable iff (reset)
        count <= CNT_W'(P_QUEUE_DEPTH));
    a_flags : assert property (@(posedge clk) disable iff (reset)
        $onehot0(reqs) && (empty == !head_vld) && (full == !ifc.in_rdy));
endmodule

// File: tb/tb_router_input_ctrl_sep.sv
module tb_router_input_ctrl_sep;
    localparam int MSG   = 44;
    localparam int N     = 4;
    localparam int D     = 2;
    localparam int DEPTH = 2;
    localparam int ID    = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    router_input_ctrl_sep_if #(.P_MSG_NBITS(MSG)) ifc ();

    router_input_ctrl_sep #(
        .P_MSG_NBITS   (MSG),
        .P_NUM_ROUTERS (N),
        .P_DEST_NBITS  (D),
        .P_QUEUE_DEPTH (DEPTH),
        .P_ROUTER_ID   (ID)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (ifc)
    );

    typedef struct {
        logic [MSG-1:0] msg;
        logic           dom;
    } pkt_t;

    typedef struct {
        bit         rst;
        bit         v;
        int         dest;
        bit         dom;
        logic [2:0] g;
        bit         e_rdy;
        logic [2:0] e_reqs;
        bit         e_dom;
        int         e_head;
    } vec_t;

    pkt_t mq[$];
    vec_t tbl[13];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [MSG-1:0] mk_msg(input int dest, input int tag);
        logic [MSG-1:0] m;
        m = '0;
        m[MSG-1 -: D] = D'(dest);
        m[31:0] = 32'(tag);
        return m;
    endfunction

    // Output port by ring distance: 0 hops -> terminal, up to half the ring -> clockwise.
    function automatic int ref_port(input logic [MSG-1:0] m);
        int dest;
        int fwd;
        dest = int'(m[MSG-1 -: D]);
        fwd  = (dest - ID + N) % N;
        if (fwd == 0) return 1;
        if (fwd <= N / 2) return 2;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit v, input int dest, input bit dom,
                         input logic [2:0] g, input int tag);
        reset         = rst;
        ifc.in_val    = v;
        ifc.in_msg    = mk_msg(dest, tag);
        ifc.in_domain = dom;
        ifc.grants_p0 = g[0];
        ifc.grants_p1 = g[1];
        ifc.grants_p2 = g[2];
    endtask

    task automatic tick();
        bit         do_enq;
        bit         do_deq;
        logic [2:0] gv;
        pkt_t       p;
        gv     = {ifc.grants_p2, ifc.grants_p1, ifc.grants_p0};
        do_enq = ifc.in_val && (mq.size() < DEPTH);
        do_deq = (mq.size() > 0) && gv[ref_port(mq[0].msg)];
        p.msg  = ifc.in_msg;
        p.dom  = ifc.in_domain;
        @(posedge clk);
        if (reset) begin
            mq.delete();
        end else begin
            if (do_deq) void'(mq.pop_front());
            if (do_enq) mq.push_back(p);
        end
        #1;
    endtask

    function automatic logic [2:0] act_reqs();
        return {ifc.reqs_p2, ifc.reqs_p1, ifc.reqs_p0};
    endfunction

    task automatic chk_model(input string tag);
        logic [2:0]     e_reqs;
        logic           e_dom;
        logic [MSG-1:0] e_head;
        e_reqs = '0;
        e_dom  = 1'b0;
        e_head = '0;
        if (mq.size() > 0) begin
            e_reqs[ref_port(mq[0].msg)] = 1'b1;
            e_dom  = mq[0].dom;
            e_head = mq[0].msg;
        end
        chk({tag, ".in_rdy"}, 64'(ifc.in_rdy), 64'(mq.size() < DEPTH));
        chk({tag, ".reqs"}, 64'(act_reqs()), 64'(e_reqs));
        chk({tag, ".reqs_domain"}, 64'(ifc.reqs_domain), 64'(e_dom));
        chk({tag, ".head_msg"}, 64'(ifc.head_msg), 64'(e_head));
    endtask

    initial begin
        logic [MSG-1:0] e_head;
        logic [2:0]     g;

        // rst v dest dom grants | rdy reqs{p2,p1,p0} dom head_row
        tbl[0]  = '{1, 1, 1, 0, 3'b000, 1, 3'b000, 0, -1};
        tbl[1]  = '{1, 1, 1, 0, 3'b000, 1, 3'b000, 0, -1};
        tbl[2]  = '{0, 1, 1, 1, 3'b000, 1, 3'b010, 1, 2};
        tbl[3]  = '{0, 1, 2, 0, 3'b010, 1, 3'b100, 0, 3};
        tbl[4]  = '{0, 1, 3, 1, 3'b100, 1, 3'b100, 1, 4};
        tbl[5]  = '{0, 1, 0, 0, 3'b100, 1, 3'b001, 0, 5};
        tbl[6]  = '{0, 0, 0, 0, 3'b001, 1, 3'b000, 0, -1};
        tbl[7]  = '{0, 1, 2, 1, 3'b000, 1, 3'b100, 1, 7};
        tbl[8]  = '{0, 1, 3, 0, 3'b000, 0, 3'b100, 1, 7};
        tbl[9]  = '{0, 1, 0, 0, 3'b000, 0, 3'b100, 1, 7};
        tbl[10] = '{0, 0, 0, 0, 3'b011, 0, 3'b100, 1, 7};
        tbl[11] = '{0, 0, 0, 0, 3'b100, 1, 3'b100, 0, 8};
        tbl[12] = '{0, 0, 0, 0, 3'b100, 1, 3'b000, 0, -1};

        for (int r = 0; r < 13; r++) begin
            drive(tbl[r].rst, tbl[r].v, tbl[r].dest, tbl[r].dom, tbl[r].g, 100 + r);
            tick();
            e_head = (tbl[r].e_head < 0) ? '0
                   : mk_msg(tbl[tbl[r].e_head].dest, 100 + tbl[r].e_head);
            chk($sformatf("vec%0d.in_rdy", r), 64'(ifc.in_rdy), 64'(tbl[r].e_rdy));
            chk($sformatf("vec%0d.reqs", r), 64'(act_reqs()), 64'(tbl[r].e_reqs));
            chk($sformatf("vec%0d.reqs_domain", r), 64'(ifc.reqs_domain), 64'(tbl[r].e_dom));
            chk($sformatf("vec%0d.head_msg", r), 64'(ifc.head_msg), 64'(e_head));
        end

        // Fill with domains 1 then 0, hold ungranted for 10 cycles with in_val kept high.
        drive(0, 1, 3, 1, 3'b000, 200);
        tick();
        drive(0, 1, 1, 0, 3'b000, 201);
        tick();
        chk("fill.in_rdy", 64'(ifc.in_rdy), 64'(0));
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 0, 3'b000, 300 + i);
            tick();
            chk_model($sformatf("hold%0d", i));
            chk($sformatf("hold%0d.head", i), 64'(ifc.head_msg), 64'(mk_msg(3, 200)));
            chk($sformatf("hold%0d.reqs", i), 64'(act_reqs()), 64'(3'b100));
        end
        // Wrong-port grants while the head waits on p2.
        drive(0, 0, 0, 0, 3'b011, 0);
        tick();
        chk("wrong_grant.head", 64'(ifc.head_msg), 64'(mk_msg(3, 200)));
        chk("wrong_grant.in_rdy", 64'(ifc.in_rdy), 64'(0));
        chk_model("wrong_grant");
        // Every grant high: only the requested port's grant dequeues.
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 3'b111, 0);
            tick();
            chk_model($sformatf("drain%0d", i));
        end
        chk("drain.head", 64'(ifc.head_msg), 64'(0));

        // Streaming: one packet per cycle, occupancy stays at one.
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 2, 1'(i), 3'b100, 400 + i);
            tick();
            chk($sformatf("stream%0d.head", i), 64'(ifc.head_msg), 64'(mk_msg(2, 400 + i)));
            chk($sformatf("stream%0d.in_rdy", i), 64'(ifc.in_rdy), 64'(1));
            chk($sformatf("stream%0d.dom", i), 64'(ifc.reqs_domain), 64'(i % 2));
        end
        drive(0, 0, 0, 0, 3'b100, 0);
        tick();
        chk_model("stream_end");

        // Reset with a full queue and grants pending.
        drive(0, 1, 0, 1, 3'b000, 500);
        tick();
        drive(0, 1, 2, 1, 3'b000, 501);
        tick();
        chk("prereset.in_rdy", 64'(ifc.in_rdy), 64'(0));
        drive(1, 1, 1, 1, 3'b111, 502);
        tick();
        chk("midreset.in_rdy", 64'(ifc.in_rdy), 64'(1));
        chk("midreset.reqs", 64'(act_reqs()), 64'(0));
        chk("midreset.reqs_domain", 64'(ifc.reqs_domain), 64'(0));
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 3'b111, 0);
            tick();
            chk($sformatf("postreset%0d.reqs", i), 64'(act_reqs()), 64'(0));
            chk($sformatf("postreset%0d.head", i), 64'(ifc.head_msg), 64'(0));
        end

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1 && mq.size() > 0) begin
                g = '0;
                g[ref_port(mq[0].msg)] = 1'b1;
            end else begin
                g = 3'($urandom_range(0, 7));
            end
            drive(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), g, 1000 + i);
            tick();
            chk_model($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
